// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational two's-complement conditional negate; with neg tied to the MSB it yields |val|.
module muldiv_abs #(
  parameter int N = 32
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);

  assign res = neg ? (~val + {{(N-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU producing {hi,lo}; one shared 2*WIDTH accumulator
// serves shift-add multiply and restoring divide, with sign fix-up applied in the FIX state.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               zero_q;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc;

  logic               sgn_op;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem2;
  logic               ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;

  assign sgn_op = ~op[0];
  assign b_zero = op[1] && (b == '0);

  muldiv_abs #(.N(WIDTH)) u_abs_a (.val(a), .neg(sgn_op & a[WIDTH-1]), .res(mag_a));
  muldiv_abs #(.N(WIDTH)) u_abs_b (.val(b), .neg(sgn_op & b[WIDTH-1]), .res(mag_b));

  muldiv_abs #(.N(2*WIDTH)) u_fix_prod (.val(acc), .neg(neg_q), .res(prod));
  muldiv_abs #(.N(WIDTH)) u_fix_quo (.val(acc[WIDTH-1:0]), .neg(neg_q), .res(quo));
  muldiv_abs #(.N(WIDTH)) u_fix_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .res(rem));

  // Multiply step: acc = {partial, multiplier}; add on LSB, shift right with carry in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mb};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}; the shifted remainder needs WIDTH+1 bits.
  assign rem2     = acc[2*WIDTH-1:WIDTH-1];
  assign ge       = rem2 >= {1'b0, mb};
  assign rem_sub  = rem2[WIDTH-1:0] - mb;
  assign div_next = {(ge ? rem_sub : rem2[WIDTH-1:0]), acc[WIDTH-2:0], ge};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      zero_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            cnt      <= '0;
            zero_q   <= b_zero;
            state    <= b_zero ? FIX : RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (zero_q) div_zero <= 1'b1;
          else if (is_div) {hi, lo} <= {rem, quo};
          else {hi, lo} <= prod;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      is_div <= op[1];
      neg_q  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= sgn_op & a[WIDTH-1];
      mb     <= mag_b;
      acc    <= {{WIDTH{1'b0}}, mag_a};
    end else if (state == RUN) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): 64-bit arithmetic reference model, directed
// corner cases, then randomized operations.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mh = '0;
  logic [W-1:0] ml = '0;
  int           total = 0;
  int           bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Reference: full-width integer arithmetic, C-like truncating signed division.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          p, q, r;
    longint unsigned pu;
    exp_t            e;
    e.dz = 1'b0;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {mh, ml} = p;
      end
      2'b01: begin
        pu = {32'b0, x} * {32'b0, y};
        {mh, ml} = pu;
      end
      default: begin
        if (y == 0) begin
          e.dz = 1'b1;
        end else if (o == 2'b10) begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          ml = q[W-1:0];
          mh = r[W-1:0];
        end else begin
          ml = x / y;
          mh = x % y;
        end
      end
    endcase
    e.hi = mh;
    e.lo = ml;
    sb.push_back(e);
  endtask

  // disturb: 0 none, 1 one-cycle start pulse mid-run, 2 start held from mid-run through done edge
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int disturb);
    int lat, bcnt, explat;
    bit seen;
    explat = (o[1] && y == 0) ? 1 : W + 1;
    model(o, x, y);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("dz_clear_on_start", {63'b0, div_zero}, 64'd0);
    bcnt = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      if (disturb != 0 && lat == 5) begin
        start = 1'b1; op = ~o; a = ~x; b = x;
      end
      @(posedge clock); #1;
      lat++;
      if (disturb == 1 && lat == 6) start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    start = 1'b0;
    chk("done_seen", {63'b0, seen}, 64'd1);
    chk("latency", lat, explat);
    chk("busy_cycles", bcnt, explat);
    @(posedge clock); #1;
    chk("done_one_cycle", {63'b0, done}, 64'd0);
    if (disturb == 2) chk("no_accept_at_done", {63'b0, busy}, 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents done.
  always @(negedge clock) begin
    if (done) begin
      chk("done_with_busy", {63'b0, busy}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e.hi});
        chk("lo", {32'b0, lo}, {32'b0, e.lo});
        chk("div_zero", {63'b0, div_zero}, {63'b0, e.dz});
      end
    end
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    #3;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dz", {63'b0, div_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    #20 reset = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd7, 32'd2, 0);
    run_op(2'b10, 32'd5, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 2);
    run_op(2'b11, 32'd9, 32'd0, 0);
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Asynchronous reset in the middle of an operation
    @(negedge clock);
    op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1111_1111; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    chk("async_rst_done", {63'b0, done}, 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_dz", {63'b0, div_zero}, 64'd0);
    mh = '0; ml = '0;
    @(negedge clock) reset = 1'b1;
    run_op(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFF3, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, (i % 9 == 4) ? 1 : 0);
    end

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", sb.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
